// File: rtl/rv32_dmem_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_dmem_lsu: RV32 load/store unit in front of a registered-read word   |
// | RAM. Macro RV32_LSU_MISALIGN_CHK_EN turns misaligned half/word into errors.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rv32_dmem_lsu #(
  parameter int DMEM_AW = 13
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [31:0]        dmem_data,
  output logic [DMEM_AW-1:0] dmem_rdaddress,
  output logic [DMEM_AW-1:0] dmem_wraddress,
  output logic               dmem_wren,
  input  logic [31:0]        dmem_q
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_MERGE = 2'd2;
  localparam logic [1:0] ERR_RSP   = 2'd3;

  logic [1:0]         state;
  logic [DMEM_AW-1:0] idx_q;
  logic [1:0]         lo_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [15:0]        wdata_q;

  logic [DMEM_AW-1:0] req_idx;
  logic [1:0]         req_lo;
  logic               req_err;
  logic               accept;
  logic               unused_addr_hi;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [31:0]        ld_data;
  logic [31:0]        merged;

  // Upper address bits wrap around the memory size.
  assign req_idx        = req_addr[DMEM_AW+1:2];
  assign unused_addr_hi = ^req_addr[31:DMEM_AW+2];
  assign req_ready      = rst_n && (state == IDLE);
  assign accept         = req_valid && req_ready;

  always_comb begin
    req_lo  = req_addr[1:0];
    req_err = (req_size == 2'b11);
`ifdef RV32_LSU_MISALIGN_CHK_EN
    if ((req_size == 2'b01 && req_addr[0]) ||
        (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`else
    if (req_size == 2'b01) req_lo[0] = 1'b0;
    if (req_size == 2'b10) req_lo    = 2'b00;
`endif
  end

  always_comb begin
    ld_byte = dmem_q[{lo_q, 3'b000} +: 8];
    ld_half = lo_q[1] ? dmem_q[31:16] : dmem_q[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_data = dmem_q;
    endcase
  end

  always_comb begin
    merged = dmem_q;
    if (size_q == 2'b00) merged[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lo_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Word stores write straight from the request; sub-word stores write the merged word.
  always_comb begin
    dmem_wren      = 1'b0;
    dmem_wraddress = req_idx;
    dmem_data      = req_wdata;
    dmem_rdaddress = (state == IDLE) ? req_idx : idx_q;
    if (state == RMW_MERGE) begin
      dmem_wren      = 1'b1;
      dmem_wraddress = idx_q;
      dmem_data      = merged;
    end else if (accept && req_we && req_size == 2'b10 && !req_err) begin
      dmem_wren = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_q     <= '0;
      lo_q      <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wdata_q   <= 16'h0000;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q   <= req_idx;
            lo_q    <= req_lo;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata[15:0];
            if (req_err)                 state     <= ERR_RSP;
            else if (!req_we)            state     <= LOAD_WAIT;
            else if (req_size == 2'b10)  rsp_valid <= 1'b1;
            else                         state     <= RMW_MERGE;
          end
        end
        LOAD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= ld_data;
          state     <= IDLE;
        end
        RMW_MERGE: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        ERR_RSP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_dmem_lsu.sv
`default_nettype none
// tb_rv32_dmem_lsu: directed + randomized checks of rv32_dmem_lsu against a byte-mask memory model.
module tb_rv32_dmem_lsu;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic req_ready, rsp_valid, rsp_err, dmem_wren;
  logic [31:0] rsp_rdata, dmem_data, mem_q;
  logic [AW-1:0] dmem_rdaddress, dmem_wraddress;

  always #5 clk = ~clk;

  rv32_dmem_lsu #(.DMEM_AW(AW)) dut (
    .clock(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dmem_data(dmem_data), .dmem_rdaddress(dmem_rdaddress),
    .dmem_wraddress(dmem_wraddress), .dmem_wren(dmem_wren), .dmem_q(mem_q)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Downstream RAM: registered read, initialised while reset is first held.
  logic [31:0] mem [0:8191];
  int init_ptr = 0;
  always @(posedge clk) begin
    if (!rst_n && init_ptr < 32) begin
      mem[init_ptr] <= init_word(init_ptr);
      init_ptr <= init_ptr + 1;
    end else if (dmem_wren) begin
      mem[dmem_wraddress] <= dmem_data;
    end
    mem_q <= mem[dmem_rdaddress];
  end

  typedef struct { int due; logic [31:0] rdata; logic err; } exp_t;
  exp_t expq[$];
  logic [31:0] ref_mem [0:31];
  int cyc = 0, free_cyc = 0, tests = 0, fails = 0, wr_cnt = 0;
  logic [31:0] last_rdata = 32'h0, last_wd = 32'h0;
  logic last_err = 1'b0;
  logic [AW-1:0] last_wa = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = rst_n && (cyc >= free_cyc);
    tests++;
    if (req_ready !== exp_rdy) begin
      fails++;
      $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
    end
    if (dmem_wren) begin
      wr_cnt++; last_wa = dmem_wraddress; last_wd = dmem_data;
    end
    tests++;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== expq[0].rdata || rsp_err !== expq[0].err) begin
        fails++;
        $display("FAIL rsp cyc=%0d: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                 cyc, rsp_valid, rsp_rdata, rsp_err, expq[0].rdata, expq[0].err);
      end
      last_rdata = rsp_rdata; last_err = rsp_err;
      void'(expq.pop_front());
    end else if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsp_unexpected cyc=%0d: got rsp_valid=%b expected 0", cyc, rsp_valid);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-lane masks over a flat word array.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    int idx, lo, nb;
    logic [63:0] mask, word, v;
    idx = int'(addr[14:2]);
    lo  = int'(addr[1:0]);
    nb  = 1 << size;
    err = (size == 2'b11);
`ifdef RV32_LSU_MISALIGN_CHK_EN
    if (!err && (lo % nb) != 0) err = 1'b1;
`else
    if (!err) lo = lo - (lo % nb);
`endif
    rdata = 32'h0;
    lat   = 1;
    if (err) return;
    mask = ((64'd1 << (8 * nb)) - 64'd1) << (8 * lo);
    word = {32'h0, ref_mem[idx]};
    if (we) begin
      ref_mem[idx] = 32'((word & ~mask) | (({32'h0, wdata} << (8 * lo)) & mask));
      if (nb == 4) lat = 0;
    end else begin
      v = (word & mask) >> (8 * lo);
      if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
      rdata = 32'(v);
    end
  endtask

  // Call only just after a rising edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int lat, n;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready !== 1'b1 && n < 20);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_timeout: got req_ready=%b expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    model(we, size, uns, addr, wdata, e.rdata, e.err, lat);
    e.due = cyc + lat;
    expq.push_back(e);
    free_cyc = cyc + lat;
  endtask

  task automatic wait_idle();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (expq.size() > 0 && n < 20) begin @(posedge clk); n++; end
    tests++;
    if (expq.size() > 0) begin
      fails++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", expq.size());
      expq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int wc;
    int gap;
    logic [31:0] a;
    logic [1:0] sz;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_wren", {31'h0, dmem_wren}, 32'h0);
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF); wait_idle();
    chk("wstore_addr", 32'(last_wa), 32'h4);
    chk("wstore_data", last_wd, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0); wait_idle();
    chk("wload", last_rdata, 32'hDEADBEEF);

    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5); wait_idle();
    chk("bstore_merge", last_wd, 32'hDEADA5EF);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0); wait_idle();
    chk("lb_signed", last_rdata, 32'hFFFFFFA5);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0); wait_idle();
    chk("lb_unsigned", last_rdata, 32'h000000A5);

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0); wait_idle();
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001); wait_idle();
    chk("hstore_merge", last_wd, 32'h80010000);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0); wait_idle();
    chk("lh_signed", last_rdata, 32'hFFFF8001);

    issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0); wait_idle();
`ifdef RV32_LSU_MISALIGN_CHK_EN
    chk("lh_misalign_err", {31'h0, last_err}, 32'h1);
    chk("lh_misalign_data", last_rdata, 32'h0);
`else
    chk("lh_misalign_err", {31'h0, last_err}, 32'h0);
    chk("lh_misalign_data", last_rdata, 32'hFFFFDEAD);
`endif

    wc = wr_cnt;
    issue(1'b1, 2'b11, 1'b0, 32'h18, 32'h12345678); wait_idle();
    chk("size11_err", {31'h0, last_err}, 32'h1);
    chk("size11_data", last_rdata, 32'h0);
    chk("size11_nowrite", 32'(wr_cnt - wc), 32'h0);

    issue(1'b1, 2'b00, 1'b0, 32'h15, 32'h0000005A);
    chk("b2b_ready_rmw", {31'h0, req_ready}, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h15, 32'h0); wait_idle();
    chk("b2b_load", last_rdata, 32'h0000005A);

    issue(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000077);
    req_valid = 1'b0;
    wc = wr_cnt;
    rst_n = 1'b0;
    expq.delete();
    ref_mem[12] = init_word(12);
    free_cyc = 0;
    @(negedge clk);
    chk("rmw_rst_wren", {31'h0, dmem_wren}, 32'h0);
    chk("rmw_rst_rsp", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmw_rst_nowrite", 32'(wr_cnt - wc), 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0); wait_idle();
    chk("rmw_rst_word", last_rdata, init_word(12));

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      a[14:7] = 8'h00;
      sz = ($urandom_range(0, 7) == 7) ? 2'b11 : 2'($urandom_range(0, 2));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        req_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    wait_idle();
    for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rv32_dmem_lsu.md
RV32_DMEM_LSU -- requirements
Module: rv32_dmem_lsu

Interface
REQ-001 SHALL provide parameter DMEM_AW, default 13, meaning word-address width of the downstream data memory (8192 x 32-bit words).
REQ-002 SHALL provide ports: clock  in  1  single clock, all logic rising-edge.
REQ-003 SHALL provide ports: rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL provide request ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_size in 2 (00 byte, 01 half, 10 word, 11 illegal); req_unsigned in 1 (loads only, zero-extend); req_addr in 32 (byte address); req_wdata in 32 (store data, right-aligned).
REQ-005 SHALL provide response ports: rsp_valid out 1 (one-cycle pulse); rsp_rdata out 32 (extended load data, 0 for stores and errors); rsp_err out 1.
REQ-006 SHALL provide memory-side ports: dmem_data out 32; dmem_rdaddress out DMEM_AW; dmem_wraddress out DMEM_AW; dmem_wren out 1; dmem_q in 32 (registered read data, valid one cycle after the address is sampled).

Function
REQ-007 SHALL implement states IDLE, LOAD_WAIT, RMW_MERGE, ERR_RSP; req_ready SHALL be 1 only in IDLE with rst_n high.
REQ-008 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1; word index = req_addr[DMEM_AW+1:2], upper bits ignored (wrap-around).
REQ-009 SHALL, in IDLE, drive dmem_rdaddress combinationally from req_addr word index; otherwise from the latched word index.
REQ-010 SHALL perform a word store in the accept cycle: dmem_wren=1, dmem_wraddress=word index, dmem_data=req_wdata; next state IDLE; rsp_valid=1 in the following cycle.
REQ-011 SHALL, for a load, go to LOAD_WAIT; in LOAD_WAIT select byte/half by latched addr[1:0], sign- or zero-extend, register into rsp_rdata with rsp_valid=1 in the next cycle (load latency 2 cycles from accept edge); return to IDLE.
REQ-012 SHALL, for byte/half stores, read the word in the accept cycle, go to RMW_MERGE, drive dmem_data = dmem_q with the addressed lane(s) replaced by req_wdata[7:0] / [15:0], dmem_wren=1, latched wraddress; rsp_valid next cycle; return to IDLE.
REQ-013 SHALL assert dmem_wren only in the cases of REQ-010 and REQ-012; never in the same cycle as a read issued for a different request.
REQ-014 SHALL hold no more than one outstanding request; req_ready=0 in LOAD_WAIT, RMW_MERGE, ERR_RSP.
REQ-015 SHALL guarantee a load accepted on the edge after a store's write edge returns the newly written data.
REQ-016 SHALL treat req_size=11 as an error: no memory write, rsp_valid=1 with rsp_err=1, rsp_rdata=0 one cycle later via ERR_RSP.

Reset
REQ-017 SHALL, while rst_n=0, force state IDLE, req_ready=0, dmem_wren=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-018 SHALL, on reset assertion mid-operation (LOAD_WAIT or RMW_MERGE), abort with no memory write and no response.

Configuration
REQ-019 SHALL, with RV32_LSU_MISALIGN_CHK_EN defined, treat half with addr[0]=1 or word with addr[1:0]!=0 as an error per REQ-016 (no memory access).
REQ-020 SHALL, without RV32_LSU_MISALIGN_CHK_EN, force the misaligned low address bits to zero, perform the access normally, and tie rsp_err=0 except for req_size=11.

Verification
REQ-021 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> wren pulse at wraddress 4; load rsp_rdata=0xDEADBEEF two cycles after accept.
REQ-022 Byte store 0xA5 to 0x11 over word 0xDEADBEEF -> written word 0xDEADA5EF; signed byte load 0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-023 Half store 0x8001 to 0x22 over 0x00000000 -> word 0x80010000; signed half load 0x22 -> 0xFFFF8001.
REQ-024 Half load at 0x13 -> rsp_err=1, rsp_rdata=0 with macro; without macro returns half at 0x12, rsp_err=0.
REQ-025 Back-to-back req_valid=1 with byte store then load same address -> req_ready low during RMW_MERGE; load returns merged byte.
REQ-026 rst_n low during RMW_MERGE of byte store to 0x30 -> dmem_wren stays 0, no rsp_valid, memory word 0x30 unchanged.
